// File: rtl/adder_pkg.sv
// Shared definitions for the word-serial wide adder.
//   state_t        : controller states
//   cnt_width()    : bit width of the slice counter for a given slice count
//   DEFAULT_CHUNK  : default slice width in bits
package adder_pkg;

    localparam int DEFAULT_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-slice build still needs a 1-bit counter to keep the logic legal.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/adder_ripple_cin.sv
// Combinational CHUNK-bit ripple adder with carry-in, built from per-bit
// propagate/generate terms.
//   a, b  : slice operands
//   cin   : carry into bit 0
//   sum   : slice sum
//   cout  : carry out of bit CHUNK-1
module adder_ripple_cin
    import adder_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK-1:0] w_p;
    logic [CHUNK-1:0] w_g;
    logic [CHUNK:0]   w_c;

    always_comb begin
        w_p    = a ^ b;
        w_g    = a & b;
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
        sum  = w_p ^ w_c[CHUNK-1:0];
        cout = w_c[CHUNK];
    end

endmodule

// File: rtl/adder_wide_seq.sv
// Word-serial wide unsigned adder. Operands are accepted in one handshake,
// then added CHUNK bits per cycle (LSB slice first) through one ripple slice
// with the carry registered between slices. The result is held until the
// consumer takes it; a new operand pair can be accepted on the same edge.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | one slice added per cycle, NCHUNK cycles
//   DONE  | result presented, held until out_ready
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake
//   in_a, in_b          : WIDTH-bit unsigned operands
//   out_valid/out_ready : result handshake
//   out_sum, out_cout   : (in_a+in_b) mod 2^WIDTH and carry out
module adder_wide_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int            NCHUNK   = WIDTH / CHUNK;
    localparam int            CW       = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    generate
        if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("adder_wide_seq: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_sum_shift;

    adder_ripple_cin #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (r_a[CHUNK-1:0]),
        .b    (r_b[CHUNK-1:0]),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // New slice enters at the top; after NCHUNK shifts the LSB slice sits at bit 0.
    // Written with shifts so a single-slice build needs no empty part-select.
    assign w_sum_shift = (r_sum >> CHUNK) | (WIDTH'(w_slice_sum) << (WIDTH - CHUNK));

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = !rst;
                if (w_accept) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Delivery and the next accept share one edge.
                in_ready  = out_ready && !rst;
                if (out_ready) begin
                    w_state_next = in_valid ? RUN : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_out_sum  <= '0;
            r_out_cout <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sum   <= w_sum_shift;
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_slice_cout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_out_sum  <= w_sum_shift;
                r_out_cout <= w_slice_cout;
            end
        end
    end

    assign out_sum  = r_out_sum;
    assign out_cout = r_out_cout;

endmodule

// File: tb/tb_adder_wide_seq.sv
module tb_adder_wide_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] in_a      = '0;
    logic [15:0] in_b      = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_cout;

    logic        v8  = 1'b0;
    logic        r8;
    logic [7:0]  a8  = '0;
    logic [7:0]  b8  = '0;
    logic        ov8;
    logic        or8 = 1'b0;
    logic [7:0]  s8;
    logic        c8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_acc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_wide_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    adder_wide_seq #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .in_ready  (r8),
        .in_a      (a8),
        .in_b      (b8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_sum   (s8),
        .out_cout  (c8)
    );

    // Reference: plain unsigned addition with one extra bit for the carry.
    function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input string tag);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_accept"}, ok, 1'b1);
        @(posedge clk);
        #1;
        t_acc    = cyc;
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
    endtask

    task automatic wait_valid(input string tag, output int lat);
        logic ok;
        ok  = 1'b0;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok  = 1'b1;
                lat = cyc - t_acc;
                break;
            end
        end
        chk({tag, "_valid"}, ok, 1'b1);
    endtask

    task automatic take(input logic [16:0] exp, input string tag);
        chk({tag, "_sum"}, out_sum, exp[15:0]);
        chk({tag, "_cout"}, out_cout, exp[16]);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input string tag);
        int lat;
        send16(a, b, tag);
        wait_valid(tag, lat);
        chk({tag, "_latency"}, lat, 4);
        take(ref16(a, b), tag);
    endtask

    logic [15:0] pa [3];
    logic [15:0] pb [3];
    logic [16:0] q16 [$];
    logic [8:0]  q8  [$];

    initial begin
        int lat;
        int prev_acc;
        logic ok;
        logic [16:0] held;
        logic [16:0] e16;
        logic [8:0]  e8;
        logic        acc16;
        logic        acc8;
        logic        hold16;
        int sent16, recv16, sent8, recv8;
        localparam int N16 = 4000;
        localparam int N8  = 4000;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 16'h0);
        chk("rst_out_cout", out_cout, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Reset in the middle of RUN drops the operation
        send16(16'h1234, 16'h1111, "abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold_valid", out_valid, 1'b0);
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_result", out_valid, 1'b0);
        end
        op16(16'h0001, 16'h0002, "after_abort");

        // Directed arithmetic corners
        op16(16'hFFFF, 16'h0001, "full_carry");
        op16(16'h0F0F, 16'h00F1, "mid_carry");
        op16(16'h8000, 16'h8000, "top_carry");

        // Backpressure: result must hold while the consumer stalls
        send16(16'hABCD, 16'h1111, "bp");
        wait_valid("bp", lat);
        held = {out_cout, out_sum};
        chk("bp_value", held, ref16(16'hABCD, 16'h1111));
        in_valid = 1'b1;
        in_a     = 16'h5555;
        in_b     = 16'h5555;
        repeat (5) begin
            @(negedge clk);
            chk("bp_stable", {out_cout, out_sum}, held);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_single_xfer", out_valid, 1'b0);
        chk("bp_idle", in_ready, 1'b1);

        // Back-to-back with in_valid held and consumer always ready
        pa[0] = 16'h7FFF; pb[0] = 16'h0001;
        pa[1] = 16'h1234; pb[1] = 16'hEDCC;
        pa[2] = 16'hC0DE; pb[2] = 16'h0F00;
        out_ready = 1'b1;
        prev_acc  = 0;
        for (int i = 0; i < 3; i++) begin
            in_a     = pa[i];
            in_b     = pb[i];
            in_valid = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("b2b_accept", ok, 1'b1);
            if (i > 0) begin
                chk("b2b_same_edge_valid", out_valid, 1'b1);
                chk("b2b_result", {out_cout, out_sum}, ref16(pa[i-1], pb[i-1]));
            end
            @(posedge clk);
            #1;
            if (i > 0) chk("b2b_period", cyc - prev_acc, 5);
            prev_acc = cyc;
            t_acc    = cyc;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        wait_valid("b2b_last", lat);
        chk("b2b_last_latency", lat, 4);
        take(ref16(pa[2], pb[2]), "b2b_last");

        // Random soak on both builds with random stalls on both sides
        sent16 = 0; recv16 = 0; sent8 = 0; recv8 = 0;
        hold16 = 1'b0;
        held   = '0;
        for (int c = 0; c < 70000; c++) begin
            if (recv16 >= N16 && recv8 >= N8) break;
            @(negedge clk);
            if (!in_valid && sent16 < N16 && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                in_a     = 16'($urandom);
                in_b     = 16'($urandom);
            end
            out_ready = ($urandom_range(3) != 0);
            if (!v8 && sent8 < N8 && $urandom_range(3) != 0) begin
                v8 = 1'b1;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            or8 = ($urandom_range(3) != 0);
            #1;
            if (hold16) chk("soak_hold16", {out_cout, out_sum}, held);
            hold16 = out_valid && !out_ready;
            held   = {out_cout, out_sum};
            if (out_valid && out_ready) begin
                chk("soak16_nonempty", q16.size() != 0, 1'b1);
                if (q16.size() != 0) begin
                    e16 = q16.pop_front();
                    chk("soak16_result", {out_cout, out_sum}, e16);
                end
                recv16++;
            end
            acc16 = in_valid && in_ready;
            if (acc16) begin
                q16.push_back(ref16(in_a, in_b));
                sent16++;
            end
            if (ov8 && or8) begin
                chk("soak8_nonempty", q8.size() != 0, 1'b1);
                if (q8.size() != 0) begin
                    e8 = q8.pop_front();
                    chk("soak8_result", {c8, s8}, e8);
                end
                recv8++;
            end
            acc8 = v8 && r8;
            if (acc8) begin
                q8.push_back(ref8(a8, b8));
                sent8++;
            end
            @(posedge clk);
            #1;
            if (acc16) begin
                in_valid = 1'b0;
                in_a     = 16'($urandom);
                in_b     = 16'($urandom);
            end
            if (acc8) begin
                v8 = 1'b0;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
        end
        out_ready = 1'b0;
        or8       = 1'b0;
        chk("soak16_count", recv16, N16);
        chk("soak8_count", recv8, N8);
        chk("soak16_drained", q16.size(), 0);
        chk("soak8_drained", q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
